// File: rtl/key_sweep_pkg.sv
// Shared types and default sizing for the key-sweep controller and its settle timer.
package key_sweep_pkg;

  localparam int DEF_KEY_W  = 2;
  localparam int DEF_PI_W   = 36;
  localparam int DEF_RESP_W = 7;
  localparam int DEF_SETTLE = 2;

  // Wide enough for any SETTLE in 1..15.
  localparam int TIMER_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/key_sweep_timer.sv
// Settle timer: load a cycle count, count down to zero, pulse expire on the last counted cycle.
module key_sweep_timer
  import key_sweep_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps latches from being inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/key_sweep_ctrl.sv
// Sweeps every key of a locked circuit against one oracle pattern and prunes the alive-key mask.
// Define KEY_SWEEP_SKIP_EN to skip keys already eliminated instead of re-testing them.
module key_sweep_ctrl
  import key_sweep_pkg::*;
#(
  parameter int KEY_W  = DEF_KEY_W,
  parameter int PI_W   = DEF_PI_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pat_valid,
  output logic                  pat_ready,
  input  logic [PI_W-1:0]       pat_pi,
  input  logic [RESP_W-1:0]     pat_gold,
  output logic [PI_W-1:0]       pi_out,
  output logic [KEY_W-1:0]      key_out,
  input  logic [RESP_W-1:0]     resp_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2**KEY_W-1:0]   alive,
  output logic                  key_found,
  output logic                  no_key,
  input  logic                  clear_mask
);

  localparam int               NKEYS    = 2**KEY_W;
  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NKEYS - 1);

`ifdef KEY_SWEEP_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    k_q, k_d;
  logic [KEY_W-1:0]    key_out_q, key_out_d;
  logic [PI_W-1:0]     pi_q, pi_d;
  logic [RESP_W-1:0]   gold_q, gold_d;
  logic [NKEYS-1:0]    alive_q, alive_d;
  logic                no_key_q, no_key_d;
  logic                timer_load, timer_expire, mismatch;

  key_sweep_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (TIMER_W'(SETTLE)),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pi_d       = pi_q;
    gold_d     = gold_q;
    key_out_d  = key_out_q;
    timer_load = 1'b0;
    mismatch   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pat_valid) begin
          pi_d    = pat_pi;
          gold_d  = pat_gold;
          k_d     = '0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (SKIP_EN && !alive_q[k_q]) begin
          if (k_q == LAST_KEY) state_d = ST_RESULT;
          else                 k_d     = k_q + 1'b1;
        end else begin
          timer_load = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (timer_expire) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        mismatch = (resp_in != gold_q);
        if (k_q == LAST_KEY) begin
          state_d = ST_RESULT;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_APPLY;
        end
      end
      ST_RESULT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear arriving with an eliminating capture overrides it.
    alive_d = alive_q;
    if (mismatch)   alive_d[k_q] = 1'b0;
    if (clear_mask) alive_d      = '1;
    no_key_d = clear_mask ? 1'b0 : (no_key_q || (alive_d == '0));

    if (SKIP_EN && (state_q == ST_IDLE) && pat_valid && (alive_d == '0)) begin
      state_d = ST_RESULT;
    end

    // key_out only moves to keys that are really applied, so skipped keys never reach the circuit.
    if ((state_d == ST_APPLY) && (!SKIP_EN || alive_d[k_d])) begin
      key_out_d = k_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      key_out_q <= '0;
      pi_q      <= '0;
      gold_q    <= '0;
      alive_q   <= '1;
      no_key_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      key_out_q <= key_out_d;
      pi_q      <= pi_d;
      gold_q    <= gold_d;
      alive_q   <= alive_d;
      no_key_q  <= no_key_d;
    end
  end

  assign pat_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESULT);
  assign pi_out    = pi_q;
  assign key_out   = key_out_q;
  assign alive     = alive_q;
  assign key_found = ($countones(alive_q) == 1);
  assign no_key    = no_key_q;

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// Directed bench for key_sweep_ctrl with a slot-schedule reference model checked every cycle.
module tb_key_sweep_ctrl;

  localparam int KW = 2;
  localparam int NK = 4;
  localparam int PW = 36;
  localparam int RW = 7;
  localparam int S  = 2;
`ifdef KEY_SWEEP_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk, rst_n;
  logic          pat_valid, pat_ready, res_valid, res_ready, clear_mask;
  logic [PW-1:0] pat_pi, pi_out;
  logic [RW-1:0] pat_gold, resp_in;
  logic [KW-1:0] key_out;
  logic [NK-1:0] alive;
  logic          key_found, no_key;

  logic [NK-1:0] good_keys;
  int            n_checks, n_errors;

  key_sweep_ctrl #(.KEY_W(KW), .PI_W(PW), .RESP_W(RW), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_pi(pat_pi), .pat_gold(pat_gold), .pi_out(pi_out), .key_out(key_out),
    .resp_in(resp_in), .res_valid(res_valid), .res_ready(res_ready), .alive(alive),
    .key_found(key_found), .no_key(no_key), .clear_mask(clear_mask)
  );

  // Stand-in locked circuit: correct response only for keys marked good.
  assign resp_in = good_keys[key_out] ? pat_gold : (pat_gold ^ 7'h55);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each key owns a time slot (S+2 cycles when tested, 1 cycle when skipped).
  int            cyc;
  bit            m_busy, m_res, m_real;
  int            m_key, m_due;
  logic [NK-1:0] m_alive;
  bit            m_nokey;
  logic [PW-1:0] m_pi;
  bit            md_was_res, md_was_idle, md_slot_end;

  task automatic begin_slot(input int k);
    m_key  = k;
    m_real = !SKIP || m_alive[k];
    m_due  = cyc + (m_real ? S + 2 : 1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_busy = 0; m_res = 0; m_real = 0; m_key = 0; m_due = 0;
      m_alive = '1; m_nokey = 0; m_pi = '0;
    end else begin
      cyc++;
      md_was_res  = m_res;
      md_was_idle = !m_busy && !m_res;
      md_slot_end = m_busy && (cyc == m_due);
      if (md_slot_end && m_real && !good_keys[m_key]) m_alive[m_key] = 1'b0;
      if (clear_mask) begin
        m_alive = '1;
        m_nokey = 0;
      end
      if (m_alive == '0) m_nokey = 1;
      if (md_was_res && res_ready) m_res = 0;
      if (md_was_idle && pat_valid) begin
        m_pi = pat_pi;
        if (SKIP && m_alive == '0) m_res = 1;
        else begin
          m_busy = 1;
          begin_slot(0);
        end
      end else if (md_slot_end) begin
        if (m_key == NK - 1) begin
          m_busy = 0;
          m_res  = 1;
        end else begin
          begin_slot(m_key + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("pat_ready", 64'(pat_ready), 64'(!m_busy && !m_res));
      check("res_valid", 64'(res_valid), 64'(m_res));
      check("alive", 64'(alive), 64'(m_alive));
      check("key_found", 64'(key_found), 64'($countones(m_alive) == 1));
      check("no_key", 64'(no_key), 64'(m_nokey));
      if (m_busy && m_real) begin
        check("key_out", 64'(key_out), 64'(m_key));
        check("pi_out", 64'(pi_out), 64'(m_pi));
      end
    end
  end

  // Stimulus: inputs change 2 time units after a rising edge.
  int t_accept;
  bit seen_nonzero_key;

  task automatic start_pattern(input logic [PW-1:0] pi, input logic [RW-1:0] gold);
    check("pat_ready_before", 64'(pat_ready), 64'(1));
    pat_pi = pi; pat_gold = gold; pat_valid = 1'b1;
    seen_nonzero_key = 1'b0;
    @(posedge clk); #2;
    t_accept  = cyc;
    pat_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    while (!res_valid && (cyc - t_accept) < 300) begin
      @(posedge clk); #2;
      if (!res_valid && key_out != '0) seen_nonzero_key = 1'b1;
    end
    check("result_timeout", 64'(res_valid), 64'(1));
    lat = cyc - t_accept + 1;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk); #2;
    res_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_mask = 1'b1;
    @(posedge clk); #2;
    clear_mask = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; pat_valid = 1'b0; res_ready = 1'b0; clear_mask = 1'b0;
    pat_pi = '0; pat_gold = '0; good_keys = 4'b0001;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    check("rst_pat_ready", 64'(pat_ready), 64'(1));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_alive", 64'(alive), 64'h0F);
    check("rst_no_key", 64'(no_key), 64'(0));
    check("rst_key_found", 64'(key_found), 64'(0));
    check("rst_pi_out", 64'(pi_out), 64'(0));
    check("rst_key_out", 64'(key_out), 64'(0));
    @(posedge clk); #2;

    // Only key 00 is correct: full sweep, one survivor.
    good_keys = 4'b0001;
    start_pattern(36'h1_2345_6789, 7'h2A);
    wait_result(lat);
    check("lat_first", 64'(lat), 64'(17));
    check("alive_one", 64'(alive), 64'h01);
    check("key_found_one", 64'(key_found), 64'(1));
    take_result();

    // Hold off the result; a new offer must be ignored meanwhile.
    start_pattern(36'hA_BCDE_F012, 7'h11);
    wait_result(lat);
    pat_pi = 36'h5_5555_5555; pat_gold = 7'h7F; pat_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_res_valid", 64'(res_valid), 64'(1));
      check("hold_pat_ready", 64'(pat_ready), 64'(0));
      check("hold_alive", 64'(alive), 64'h01);
    end
    @(posedge clk); #2 pat_valid = 1'b0;
    take_result();

    // No key is correct: mask empties and no_key sticks across the next pattern.
    good_keys = 4'b0000;
    start_pattern(36'h0_0F0F_0F0F, 7'h33);
    wait_result(lat);
    check("alive_zero", 64'(alive), 64'h00);
    check("no_key_set", 64'(no_key), 64'(1));
    check("key_found_zero", 64'(key_found), 64'(0));
    take_result();
    start_pattern(36'h3_0000_0001, 7'h44);
    wait_result(lat);
    check("no_key_sticky", 64'(no_key), 64'(1));
    take_result();
    pulse_clear();
    @(negedge clk);
    check("clear_alive", 64'(alive), 64'h0F);
    check("clear_no_key", 64'(no_key), 64'(0));
    @(posedge clk); #2;

    // Clear coincides with the mismatching capture of key 1; keys 2 and 3 still apply.
    good_keys = 4'b0001;
    start_pattern(36'h7_7777_0000, 7'h05);
    repeat (7) @(posedge clk);
    #2 clear_mask = 1'b1;
    @(posedge clk); #2 clear_mask = 1'b0;
    @(negedge clk);
    check("clear_wins", 64'(alive), 64'h0F);
    wait_result(lat);
    check("alive_after_clear_sweep", 64'(alive), 64'h03);
    take_result();

    // Reset during the SETTLE phase of key 2 discards the sweep.
    pulse_clear();
    start_pattern(36'h9_8765_4321, 7'h60);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_res_valid", 64'(res_valid), 64'(0));
    check("midrst_pat_ready", 64'(pat_ready), 64'(1));
    check("midrst_alive", 64'(alive), 64'h0F);
    check("midrst_pi_out", 64'(pi_out), 64'(0));
    check("midrst_key_out", 64'(key_out), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_result", 64'(res_valid), 64'(0));
    @(posedge clk); #2;

    // Second pattern with one survivor: skipped keys shorten the sweep when enabled.
    good_keys = 4'b0001;
    start_pattern(36'h2_4681_3579, 7'h1C);
    wait_result(lat);
    check("lat_full", 64'(lat), 64'(17));
    take_result();
    start_pattern(36'hC_AFE0_BEEF, 7'h2D);
    wait_result(lat);
    check("lat_second", 64'(lat), 64'(SKIP ? 8 : 17));
    check("dead_keys_driven", 64'(seen_nonzero_key), 64'(SKIP ? 0 : 1));
    check("alive_second", 64'(alive), 64'h01);
    take_result();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_sweep_ctrl.md
KEY_SWEEP_CTRL -- requirements
Module: key_sweep_ctrl

Interface
REQ-001 SHALL have parameters: KEY_W, default 2, key width; PI_W, default 36, locked-circuit primary-input width; RESP_W, default 7, response width; SETTLE, default 2, wait cycles per key (1..15).
REQ-002 SHALL have ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 pat_valid in 1 pattern offered; pat_ready out 1 pattern accepted when both high.
REQ-004 pat_pi in PI_W input pattern; pat_gold in RESP_W oracle response for pat_pi.
REQ-005 pi_out out PI_W drive to locked circuit; key_out out KEY_W key drive to locked circuit.
REQ-006 resp_in in RESP_W locked-circuit response.
REQ-007 res_valid out 1; res_ready in 1; alive out 2**KEY_W surviving-key mask.
REQ-008 key_found out 1 exactly one key alive; no_key out 1 sticky, all keys eliminated.
REQ-009 clear_mask in 1 one-cycle pulse restoring all keys alive and clearing no_key.

Function
REQ-010 States SHALL be IDLE, APPLY, SETTLE, CAPTURE, RESULT.
REQ-011 pat_ready SHALL be high only in IDLE; handshake latches pat_pi/pat_gold, sets key index k=0, goes to APPLY.
REQ-012 APPLY (1 cycle) SHALL drive pi_out=latched pattern, key_out=k, load settle counter with SETTLE.
REQ-013 SETTLE SHALL hold pi_out/key_out stable for exactly SETTLE cycles, then CAPTURE.
REQ-014 CAPTURE (1 cycle) SHALL compare resp_in to latched gold; mismatch clears alive[k].
REQ-015 After CAPTURE, k<2**KEY_W-1 SHALL increment k (no wrap) and go to APPLY; else go to RESULT.
REQ-016 RESULT SHALL hold res_valid high until res_ready; on handshake return to IDLE; res_valid low elsewhere.
REQ-017 Per-pattern latency with all keys swept: 1 (accept) + 2**KEY_W*(SETTLE+2) cycles to res_valid.
REQ-018 key_found = popcount(alive)==1, no_key set when alive becomes zero; both combinational from registered alive/no_key state.
REQ-019 alive SHALL persist across patterns; only reset or clear_mask restores it.
REQ-020 clear_mask coincident with a CAPTURE mismatch: clear SHALL win (all ones).
REQ-021 clear_mask outside IDLE SHALL not abort the sweep; later captures of the same sweep still apply.
REQ-022 pat_valid outside IDLE SHALL be ignored; pattern must be held until accepted.

Reset
REQ-023 On rst_n low: state IDLE, k=0, alive all ones, no_key 0, res_valid 0, pat_ready 1 after release, pi_out 0, key_out 0.
REQ-024 Reset mid-sweep SHALL discard the sweep with no result issued.

Configuration
REQ-025 KEY_SWEEP_SKIP_EN defined: APPLY/SETTLE/CAPTURE SHALL be skipped for keys with alive[k]=0 (k advances in one cycle); if no key alive, go directly to RESULT.
REQ-026 KEY_SWEEP_SKIP_EN undefined: every key SHALL be swept; latency fixed per REQ-017.

Structure
REQ-027 Package key_sweep_pkg SHALL hold the state enum and default width/SETTLE constants.
REQ-028 Settle counter SHALL be sub-module key_sweep_timer (load, count-down, expire pulse).

Verification
REQ-029 Model keeps output correct only for key 2'b00 (mismatch for 01,10,11); one pattern -> res_valid after 17 cycles (SETTLE=2), alive=4'b0001, key_found=1.
REQ-030 Model mismatches every key -> alive=4'b0000, no_key=1 sticky across next pattern until clear_mask, then alive=4'b1111, no_key=0.
REQ-031 res_ready held low 5 cycles in RESULT -> res_valid and alive stable, pat_ready 0, pat_valid ignored.
REQ-032 rst_n asserted during SETTLE of key 2 -> outputs at reset values next cycle, no res_valid.
REQ-033 clear_mask in same cycle as mismatching CAPTURE -> alive=4'b1111 afterwards.
REQ-034 With KEY_SWEEP_SKIP_EN and alive=4'b0001 -> second pattern result after 1+4+3 cycles, only key 00 driven on key_out.
